// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
//   Decode-side operand stage behind a 2-read/1-write register file.
//   Drives the register file read addresses, resolves forwarding from
//   EX/MEM/WB, inserts bubbles on load-use hazards and registers the
//   resolved operands into the ID/EX register with a valid/ready handshake.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       IF/ID handshake
//   in_instr, in_pc         incoming instruction word and PC
//   rf_ra1/2, rf_rd1/2      register file read addresses / data
//   ex_*, mem_*, wb_*       producer write enables, destinations and values
//   flush                   squashes the ID/EX register, blocks acceptance
//   out_valid/out_ready     ID/EX handshake
//   out_pc, out_instr       registered payload
//   out_rs1_val/rs2_val     registered resolved operands
//   stall_cnt               saturating count of hazard bubbles
module operand_fetch_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic [4:0]       rf_ra1,
  output logic [4:0]       rf_ra2,
  input  logic [XLEN-1:0]  rf_rd1,
  input  logic [XLEN-1:0]  rf_rd2,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [XLEN-1:0]  ex_result,
  input  logic             mem_we,
  input  logic             mem_is_load,
  input  logic [4:0]       mem_rd,
  input  logic [XLEN-1:0]  mem_result,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_rs1_val,
  output logic [XLEN-1:0]  out_rs2_val,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic            w_uses_rs1;
  logic            w_uses_rs2;
  logic            w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2, w_wb_m1, w_wb_m2;
  logic            w_hazard;
  logic            w_advance;
  logic            w_xfer;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;

  logic             r_out_valid;
  logic [31:0]      r_out_pc;
  logic [31:0]      r_out_instr;
  logic [XLEN-1:0]  r_rs1_val;
  logic [XLEN-1:0]  r_rs2_val;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_opcode = in_instr[6:0];
  assign w_rs1    = in_instr[19:15];
  assign w_rs2    = in_instr[24:20];
  assign rf_ra1   = w_rs1;
  assign rf_ra2   = w_rs2;

  always_comb begin
    w_uses_rs1 = 1'b1;
    w_uses_rs2 = 1'b0;
    if (w_opcode == OP_LUI || w_opcode == OP_AUIPC || w_opcode == OP_JAL)
      w_uses_rs1 = 1'b0;
    if (w_opcode == OP_R || w_opcode == OP_S || w_opcode == OP_B)
      w_uses_rs2 = 1'b1;
  end

  function automatic logic f_match(input logic we, input logic [4:0] rd,
                                   input logic [4:0] src, input logic used);
    return we && (rd != 5'd0) && (rd == src) && used;
  endfunction

  // Unused sources pass the regfile value through untouched; used x0 is
  // forced to zero so no producer can ever override it.
  function automatic logic [XLEN-1:0] f_resolve(
      input logic used, input logic [4:0] src,
      input logic ex_m, input logic mem_m, input logic wb_m,
      input logic [XLEN-1:0] rf);
    if (!used)             return rf;
    else if (src == 5'd0)  return '0;
    else if (ex_m)         return ex_result;
    else if (mem_m)        return mem_result;
    else if (wb_m)         return wb_data;
    else                   return rf;
  endfunction

  assign w_ex_m1  = f_match(ex_we,  ex_rd,  w_rs1, w_uses_rs1);
  assign w_ex_m2  = f_match(ex_we,  ex_rd,  w_rs2, w_uses_rs2);
  assign w_mem_m1 = f_match(mem_we, mem_rd, w_rs1, w_uses_rs1);
  assign w_mem_m2 = f_match(mem_we, mem_rd, w_rs2, w_uses_rs2);
  // WB forwarding covers the write-at-edge regfile returning stale data.
  assign w_wb_m1  = f_match(wb_we,  wb_rd,  w_rs1, w_uses_rs1);
  assign w_wb_m2  = f_match(wb_we,  wb_rd,  w_rs2, w_uses_rs2);

  assign w_hazard = in_valid &&
                    ((ex_is_load  && (w_ex_m1  || w_ex_m2)) ||
                     (mem_is_load && (w_mem_m1 || w_mem_m2)));

  assign w_rs1_val = f_resolve(w_uses_rs1, w_rs1, w_ex_m1, w_mem_m1, w_wb_m1, rf_rd1);
  assign w_rs2_val = f_resolve(w_uses_rs2, w_rs2, w_ex_m2, w_mem_m2, w_wb_m2, rf_rd2);

  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = w_advance && !w_hazard && !flush;
  assign w_xfer    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_instr <= '0;
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_pc    <= in_pc;
        r_out_instr <= in_instr;
        r_rs1_val   <= w_rs1_val;
        r_rs2_val   <= w_rs2_val;
      end else if (w_advance) begin
        r_out_valid <= 1'b0;
      end
      if (w_hazard && w_advance && !flush && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_pc      = r_out_pc;
  assign out_instr   = r_out_instr;
  assign out_rs1_val = r_rs1_val;
  assign out_rs2_val = r_rs2_val;
  assign stall_cnt   = r_stall_cnt;

endmodule
